mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the pipeline control word: takes mem_read, mem_write and funct3 for the instruction in MEM, plus the ALU address and rs2 data.
- Drives a single-outstanding data-memory request/response port.
- Formats store data and byte enables; aligns and sign/zero-extends load data.
- Stalls the pipeline until the access completes.

Parameters:
- TIMEOUT_CYCLES, 0, cycles to wait for dmem_resp before aborting with err_o; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  MEM stage holds a valid instruction
- mem_read_i  in  1  control word mem_read
- mem_write_i  in  1  control word mem_write
- funct3_i  in  3  control word funct3 (load_funct3_t / store_funct3_t encoding)
- addr_i  in  32  byte address from ALU
- store_data_i  in  32  rs2 value
- advance_i  in  1  pipeline advances MEM->WB this cycle
- stall_o  out  1  hold pipeline
- load_data_o  out  32  formatted load result
- err_o  out  1  misaligned, illegal funct3, or timeout; valid in DONE
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_address  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_byte_enable  out  4  write lane mask
- dmem_rdata  in  32  read data
- dmem_resp  in  1  one-cycle completion pulse

Behaviour:
- States: IDLE, BUSY, DONE. Reset: state IDLE.
- Reset values: all outputs 0, timeout counter 0.
- Output registration: all dmem_* outputs are registered.
- IDLE, no access: when not (valid_i & (mem_read_i | mem_write_i)), stay IDLE with stall_o=0.
- IDLE, access request (op = valid_i & (mem_read_i | mem_write_i)): stall_o=1 combinationally.
  - Legal access: latch the request and go to BUSY.
  - Illegal access: go directly to DONE with err_o=1, load_data_o=0 and no memory request. Illegal means:
    - funct3 not in {lb,lh,lw,lbu,lhu} for a read, or not in {sb,sh,sw} for a write;
    - half access with addr[0]=1;
    - word access with addr[1:0]!=0.
- Both mem_read_i and mem_write_i set: treat as a write (write wins). The read is not performed.
- Store formatting (off = addr[1:0]):
  - sb: wdata={4{d[7:0]}}, byte_enable=4'b0001<<off.
  - sh: wdata={2{d[15:0]}}, byte_enable=4'b0011<<off.
  - sw: wdata=d, byte_enable=4'b1111.
- Reads: byte_enable=4'b1111.
- BUSY:
  - dmem_read/dmem_write and all request fields are held stable until dmem_resp. stall_o=1.
  - On dmem_resp: capture dmem_rdata, format it, drop the requests, go to DONE.
  - Load formatting: lb/lh sign-extend, lbu/lhu zero-extend the selected byte/half (byte off, half off[1]); lw passes through.
  - Store completion: load_data_o=0.
- Timeout (TIMEOUT_CYCLES=N>0): a counter increments each BUSY cycle. When it reaches N without dmem_resp: drop the request, go to DONE with err_o=1.
- DONE:
  - stall_o=0; load_data_o and err_o stable.
  - On advance_i: go to IDLE and clear err_o. load_data_o is held until the next capture.
- Latency: request accepted cycle T; dmem_* asserted T+1; resp at cycle R; stall_o low and load_data_o valid at R+1. Minimum 3 cycles with zero-wait memory.
- dmem_resp outside BUSY is ignored.
- rst in any state: immediate return to IDLE, requests dropped next edge; a late resp is ignored.
- valid_i / control inputs changing while BUSY are ignored; the latched request is used.

Decomposition:
- Add mem_state_t enum (IDLE, BUSY, DONE) to the shared rv32i_types package.
- Reuse load_funct3_t and store_funct3_t from that package.
- One combinational sub-module, load_formatter: inputs funct3, off, rdata; output formatted word. Reused by the bench as a reference model.

Test Plan:
- sw addr=0x100, data=0xDEADBEEF, resp 2 cycles after request -> dmem_write=1, address 0x100, be=1111, wdata=0xDEADBEEF held until resp; stall_o falls the cycle after resp.
- sb addr=0x103, data=0x000000A5 -> be=1000, wdata=0xA5A5A5A5, address 0x100.
- lb addr=0x202, rdata=0x12F0_3456 -> load_data_o=0xFFFFFFF0. Same with lbu -> 0x000000F0. lhu addr=0x202 -> 0x000012F0.
- lw addr=0x301 -> no dmem_read ever asserted, DONE next cycle with err_o=1, load_data_o=0; lh addr=0x303 -> same.
- TIMEOUT_CYCLES=4, lw with no resp -> err_o=1 after 4 BUSY cycles, request dropped. A late resp is ignored and state stays IDLE after advance_i.
- rst asserted in BUSY mid-read -> next cycle dmem_read=0, stall_o=0, state IDLE; a resp in the following cycle changes nothing.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: load/store funct3 encodings and the MEM-stage access FSM states.
package rv32i_types;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Known funct3 and natural alignment; a write is judged by the store encoding only.
    function automatic logic access_legal(input logic is_write, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (is_write) begin
            case (f3)
                sb:      ok = 1'b1;
                sh:      ok = ~off[0];
                sw:      ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (f3)
                lb, lbu: ok = 1'b1;
                lh, lhu: ok = ~off[0];
                lw:      ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it per load funct3.
module load_formatter
    import rv32i_types::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            lb:      data_o = {{24{byte_sel[7]}}, byte_sel};
            lh:      data_o = {{16{half_sel[15]}}, half_sel};
            lw:      data_o = rdata_i;
            lbu:     data_o = {24'b0, byte_sel};
            lhu:     data_o = {16'b0, half_sel};
            default: data_o = 32'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit, single outstanding request.
// IDLE: no access | BUSY: request on dmem, waiting for resp | DONE: result/err held until advance_i
module mem_access_unit
    import rv32i_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic        advance_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        err_o,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
);

    mem_state_t  state_q, state_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] load_q, load_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;

    logic        op;
    logic [31:0] fmt_data;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;

    load_formatter u_load_formatter (
        .funct3_i (funct3_q),
        .off_i    (off_q),
        .rdata_i  (dmem_rdata),
        .data_o   (fmt_data)
    );

    always_comb begin
        case (funct3_i)
            sb: begin
                st_wdata = {4{store_data_i[7:0]}};
                st_be    = 4'b0001 << addr_i[1:0];
            end
            sh: begin
                st_wdata = {2{store_data_i[15:0]}};
                st_be    = 4'b0011 << addr_i[1:0];
            end
            default: begin
                st_wdata = store_data_i;
                st_be    = 4'b1111;
            end
        endcase
    end

    assign op = valid_i & (mem_read_i | mem_write_i);

    always_comb begin
        state_d  = state_q;
        read_d   = read_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        load_d   = load_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        stall_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (op) begin
                    stall_o = 1'b1;
                    if (access_legal(mem_write_i, funct3_i, addr_i[1:0])) begin
                        state_d  = BUSY;
                        write_d  = mem_write_i;
                        read_d   = ~mem_write_i;
                        addr_d   = {addr_i[31:2], 2'b00};
                        off_d    = addr_i[1:0];
                        funct3_d = funct3_i;
                        wdata_d  = mem_write_i ? st_wdata : 32'b0;
                        be_d     = mem_write_i ? st_be : 4'b1111;
                        cnt_d    = 32'b0;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        load_d  = 32'b0;
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (dmem_resp) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    load_d  = write_q ? 32'b0 : fmt_data;
                    err_d   = 1'b0;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1))) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    load_d  = 32'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DONE: begin
                if (advance_i) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            be_q     <= 4'b0;
            funct3_q <= 3'b0;
            off_q    <= 2'b0;
            load_q   <= 32'b0;
            err_q    <= 1'b0;
            cnt_q    <= 32'b0;
        end else begin
            state_q  <= state_d;
            read_q   <= read_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            load_q   <= load_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign load_data_o      = load_q;
    assign err_o            = err_q;
    assign dmem_read        = read_q;
    assign dmem_write       = write_q;
    assign dmem_address     = addr_q;
    assign dmem_wdata       = wdata_q;
    assign dmem_byte_enable = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected load/err results are queued at stimulus time.
module tb_mem_access_unit;
    import rv32i_types::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, mem_read_i, mem_write_i, advance_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, store_data_i;
    logic        stall_o, err_o;
    logic [31:0] load_data_o;
    logic        dmem_read, dmem_write, dmem_resp;
    logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_byte_enable;

    logic [2:0]  fmt_f3;
    logic [1:0]  fmt_off;
    logic [31:0] fmt_rdata, fmt_data;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .funct3_i(funct3_i), .addr_i(addr_i),
        .store_data_i(store_data_i), .advance_i(advance_i), .stall_o(stall_o),
        .load_data_o(load_data_o), .err_o(err_o), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    load_formatter u_fmt (
        .funct3_i(fmt_f3), .off_i(fmt_off), .rdata_i(fmt_rdata), .data_o(fmt_data)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t scb[$];
    int checks = 0;
    int passed = 0;

    logic        obs_stall_acc, obs_seen_req, obs_stable;
    logic        obs_rd, obs_wr, obs_rd_end, obs_wr_end, obs_stall_done;
    logic [31:0] obs_addr, obs_wdata, obs_load, obs_load_late;
    logic [3:0]  obs_be;
    logic        obs_err, obs_err_late, obs_err_adv;
    logic        obs_idle_stall, obs_idle_rd, obs_idle_err;
    int          obs_cycles;

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = w >> (32'(off) * 8);
        b = shifted[7:0];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return w;
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return 32'b0;
        endcase
    endfunction

    // Drives one access and a zero/late response; records what the DUT did.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input int resp_delay,
                              input logic late_resp);
        valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
        addr_i = addr; store_data_i = sdata;
        #1 obs_stall_acc = stall_o;
        @(posedge clk); #1;
        mem_read_i = 1'b1; mem_write_i = 1'b1; funct3_i = 3'b000;
        addr_i = ~addr; store_data_i = ~sdata;
        obs_seen_req = 1'b0; obs_stable = 1'b1; obs_cycles = 0;
        obs_rd = 1'b0; obs_wr = 1'b0; obs_addr = '0; obs_wdata = '0; obs_be = '0;
        while (stall_o === 1'b1) begin
            if (obs_cycles == 0) begin
                obs_seen_req = dmem_read | dmem_write;
                obs_rd = dmem_read; obs_wr = dmem_write; obs_addr = dmem_address;
                obs_wdata = dmem_wdata; obs_be = dmem_byte_enable;
            end else if ({dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable} !==
                         {obs_rd, obs_wr, obs_addr, obs_wdata, obs_be}) begin
                obs_stable = 1'b0;
            end
            if (obs_cycles == resp_delay) begin
                dmem_resp = 1'b1; dmem_rdata = rdata;
            end
            @(posedge clk); #1;
            dmem_resp = 1'b0; dmem_rdata = 32'h0BAD_F00D;
            obs_cycles++;
            if (obs_cycles > 40) begin
                checks++;
                $display("FAIL access_bound: stall_o still %b after %0d cycles, required 0", stall_o, obs_cycles);
                break;
            end
        end
        if (dmem_read | dmem_write) obs_seen_req = 1'b1;
        obs_load = load_data_o; obs_err = err_o; obs_stall_done = stall_o;
        obs_rd_end = dmem_read; obs_wr_end = dmem_write;
        valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        obs_load_late = obs_load; obs_err_late = obs_err;
        if (late_resp) begin
            dmem_resp = 1'b1; dmem_rdata = 32'h5A5A_5A5A;
            @(posedge clk); #1;
            dmem_resp = 1'b0;
            obs_load_late = load_data_o; obs_err_late = err_o;
        end
        advance_i = 1'b1;
        @(posedge clk); #1;
        advance_i = 1'b0;
        obs_err_adv = err_o;
        obs_idle_stall = stall_o; obs_idle_rd = dmem_read; obs_idle_err = err_o;
        if (late_resp) begin
            dmem_resp = 1'b1; dmem_rdata = 32'h5A5A_5A5A;
            @(posedge clk); #1;
            dmem_resp = 1'b0;
            obs_idle_stall = stall_o; obs_idle_rd = dmem_read; obs_idle_err = err_o;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({stall_o, load_data_o, err_o, dmem_read, dmem_write, dmem_address, dmem_wdata,
             dmem_byte_enable} !== '0)
            $display("FAIL reset_outputs: stall=%b load=%h err=%b rd=%b wr=%b addr=%h wdata=%h be=%b, required all 0",
                     stall_o, load_data_o, err_o, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable);
        else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({stall_o, dmem_read, dmem_write, err_o} !== 4'b0)
            $display("FAIL reset_idle: stall=%b rd=%b wr=%b err=%b, required 0", stall_o, dmem_read, dmem_write, err_o);
        else passed++;
    endtask

    task automatic test_store_word();
        exp_t e;
        scb.push_back('{data: 32'h0, err: 1'b0});
        run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2, 1'b0);
        checks++;
        if (obs_stall_acc !== 1'b1) $display("FAIL sw_stall_accept: got %b required 1", obs_stall_acc); else passed++;
        checks++;
        if ({obs_wr, obs_rd} !== 2'b10) $display("FAIL sw_req: wr/rd got %b required 10", {obs_wr, obs_rd}); else passed++;
        checks++;
        if ({obs_addr, obs_be, obs_wdata} !== {32'h100, 4'b1111, 32'hDEADBEEF})
            $display("FAIL sw_fields: addr=%h be=%b wdata=%h required 00000100 1111 deadbeef", obs_addr, obs_be, obs_wdata);
        else passed++;
        checks++;
        if (obs_stable !== 1'b1) $display("FAIL sw_stable: request changed before resp (%b) required 1", obs_stable); else passed++;
        checks++;
        if (obs_cycles != 3) $display("FAIL sw_latency: stall fell after %0d busy cycles required 3", obs_cycles); else passed++;
        checks++;
        if (obs_wr_end !== 1'b0) $display("FAIL sw_drop: dmem_write got %b required 0", obs_wr_end); else passed++;
        e = scb.pop_front();
        checks++;
        if ({obs_load, obs_err} !== {e.data, e.err})
            $display("FAIL sw_result: load=%h err=%b required %h %b", obs_load, obs_err, e.data, e.err);
        else passed++;
    endtask

    task automatic test_store_narrow();
        exp_t e;
        scb.push_back('{data: 32'h0, err: 1'b0});
        run_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 1'b0);
        checks++;
        if ({obs_wr, obs_addr, obs_be, obs_wdata} !== {1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5})
            $display("FAIL sb_fields: wr=%b addr=%h be=%b wdata=%h required 1 00000100 1000 a5a5a5a5",
                     obs_wr, obs_addr, obs_be, obs_wdata);
        else passed++;
        e = scb.pop_front();
        checks++;
        if ({obs_load, obs_err} !== {e.data, e.err})
            $display("FAIL sb_result: load=%h err=%b required %h %b", obs_load, obs_err, e.data, e.err);
        else passed++;

        scb.push_back('{data: 32'h0, err: 1'b0});
        run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 0, 1'b0);
        checks++;
        if ({obs_wr, obs_addr, obs_be, obs_wdata} !== {1'b1, 32'h100, 4'b1100, 32'hBEEFBEEF})
            $display("FAIL sh_fields: wr=%b addr=%h be=%b wdata=%h required 1 00000100 1100 beefbeef",
                     obs_wr, obs_addr, obs_be, obs_wdata);
        else passed++;
        checks++;
        if (obs_cycles != 1) $display("FAIL sh_min_latency: got %0d busy cycles required 1", obs_cycles); else passed++;
        e = scb.pop_front();
        checks++;
        if ({obs_load, obs_err} !== {e.data, e.err})
            $display("FAIL sh_result: load=%h err=%b required %h %b", obs_load, obs_err, e.data, e.err);
        else passed++;
    endtask

    task automatic test_loads();
        logic [2:0]  f3 [6]  = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010, 3'b000};
        logic [31:0] ad [6]  = '{32'h202, 32'h202, 32'h202, 32'h200, 32'h204, 32'h201};
        logic [31:0] rd [6]  = '{32'h12F03456, 32'h12F03456, 32'h12F03456, 32'h00008001,
                                 32'hCAFEBABE, 32'h00007F00};
        logic [31:0] ex [6]  = '{32'hFFFFFFF0, 32'h000000F0, 32'h000012F0, 32'hFFFF8001,
                                 32'hCAFEBABE, 32'h0000007F};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            scb.push_back('{data: ex[i], err: 1'b0});
            run_access(1'b1, 1'b0, f3[i], ad[i], 32'h0, rd[i], i % 3, 1'b0);
            checks++;
            if ({obs_rd, obs_wr, obs_addr, obs_be} !== {2'b10, ad[i][31:2], 2'b00, 4'b1111})
                $display("FAIL load%0d_req: rd=%b wr=%b addr=%h be=%b required 1 0 %h 1111",
                         i, obs_rd, obs_wr, obs_addr, obs_be, {ad[i][31:2], 2'b00});
            else passed++;
            e = scb.pop_front();
            checks++;
            if ({obs_load, obs_err} !== {e.data, e.err})
                $display("FAIL load%0d_result: load=%h err=%b required %h %b", i, obs_load, obs_err, e.data, e.err);
            else passed++;
        end
    endtask

    task automatic test_illegal();
        logic        rdv [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3  [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b001};
        logic [31:0] ad  [5] = '{32'h301, 32'h303, 32'h300, 32'h300, 32'h101};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            scb.push_back('{data: 32'h0, err: 1'b1});
            run_access(rdv[i], ~rdv[i], f3[i], ad[i], 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
            checks++;
            if ({obs_stall_acc, obs_seen_req, obs_rd_end, obs_wr_end} !== 4'b1000 || obs_cycles != 0)
                $display("FAIL illegal%0d_noreq: stall_acc=%b req_seen=%b busy_cycles=%0d required 1 0 0",
                         i, obs_stall_acc, obs_seen_req, obs_cycles);
            else passed++;
            e = scb.pop_front();
            checks++;
            if ({obs_load, obs_err} !== {e.data, e.err})
                $display("FAIL illegal%0d_result: load=%h err=%b required %h %b", i, obs_load, obs_err, e.data, e.err);
            else passed++;
            checks++;
            if (obs_err_adv !== 1'b0) $display("FAIL illegal%0d_err_clear: err=%b required 0", i, obs_err_adv); else passed++;
        end
    endtask

    task automatic test_write_wins();
        exp_t e;
        scb.push_back('{data: 32'h0, err: 1'b0});
        run_access(1'b1, 1'b1, 3'b010, 32'h400, 32'h11223344, 32'hFFFFFFFF, 1, 1'b0);
        checks++;
        if ({obs_wr, obs_rd, obs_wdata} !== {2'b10, 32'h11223344})
            $display("FAIL write_wins: wr=%b rd=%b wdata=%h required 1 0 11223344", obs_wr, obs_rd, obs_wdata);
        else passed++;
        e = scb.pop_front();
        checks++;
        if ({obs_load, obs_err} !== {e.data, e.err})
            $display("FAIL write_wins_result: load=%h err=%b required %h %b", obs_load, obs_err, e.data, e.err);
        else passed++;
    endtask

    task automatic test_timeout();
        exp_t e;
        scb.push_back('{data: 32'h0, err: 1'b1});
        run_access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0, -1, 1'b1);
        checks++;
        if (obs_cycles != int'(TO)) $display("FAIL timeout_cycles: got %0d busy cycles required %0d", obs_cycles, TO); else passed++;
        checks++;
        if ({obs_rd_end, obs_stall_done} !== 2'b00)
            $display("FAIL timeout_drop: rd=%b stall=%b required 0 0", obs_rd_end, obs_stall_done);
        else passed++;
        e = scb.pop_front();
        checks++;
        if (obs_err !== e.err) $display("FAIL timeout_err: err=%b required %b", obs_err, e.err); else passed++;
        checks++;
        if ({obs_err_late, obs_load_late} !== {1'b1, obs_load})
            $display("FAIL timeout_late_done: err=%b load=%h required 1 %h", obs_err_late, obs_load_late, obs_load);
        else passed++;
        checks++;
        if ({obs_idle_stall, obs_idle_rd, obs_idle_err} !== 3'b000)
            $display("FAIL timeout_late_idle: stall=%b rd=%b err=%b required 0 0 0", obs_idle_stall, obs_idle_rd, obs_idle_err);
        else passed++;
    endtask

    task automatic test_reset_busy();
        valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h600;
        @(posedge clk); #1;
        valid_i = 1'b0; mem_read_i = 1'b0;
        checks++;
        if (dmem_read !== 1'b1) $display("FAIL rstbusy_req: dmem_read=%b required 1", dmem_read); else passed++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({dmem_read, stall_o, err_o, load_data_o} !== '0)
            $display("FAIL rstbusy_drop: rd=%b stall=%b err=%b load=%h required 0", dmem_read, stall_o, err_o, load_data_o);
        else passed++;
        dmem_resp = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        checks++;
        if ({dmem_read, stall_o, err_o, load_data_o} !== '0)
            $display("FAIL rstbusy_late_resp: rd=%b stall=%b err=%b load=%h required 0", dmem_read, stall_o, err_o, load_data_o);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  fl [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [31:0] a, w;
        logic [2:0]  f3;
        int          dly;
        exp_t        e;
        for (int i = 0; i < 8; i++) begin
            f3 = fl[$urandom_range(0, 4)];
            a = $urandom();
            w = $urandom();
            if (f3 == 3'b010) a[1:0] = 2'b00;
            else if (f3 == 3'b001 || f3 == 3'b101) a[0] = 1'b0;
            dly = $urandom_range(0, 2);
            scb.push_back('{data: exp_load(f3, a[1:0], w), err: 1'b0});
            run_access(1'b1, 1'b0, f3, a, 32'h0, w, dly, 1'b0);
            e = scb.pop_front();
            checks++;
            if ({obs_load, obs_err} !== {e.data, e.err} || obs_cycles != dly + 1)
                $display("FAIL b2b%0d: f3=%b addr=%h load=%h err=%b cycles=%0d required %h %b %0d",
                         i, f3, a, obs_load, obs_err, obs_cycles, e.data, e.err, dly + 1);
            else passed++;
        end
    endtask

    task automatic test_formatter();
        logic [2:0] fl [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 5; i++) begin
            for (int o = 0; o < 4; o++) begin
                fmt_f3 = fl[i]; fmt_off = 2'(o); fmt_rdata = $urandom() | 32'h80808080;
                #1;
                checks++;
                if (fmt_data !== exp_load(fmt_f3, fmt_off, fmt_rdata))
                    $display("FAIL formatter_f%b_o%0d: got %h required %h", fmt_f3, o, fmt_data,
                             exp_load(fmt_f3, fmt_off, fmt_rdata));
                else passed++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; advance_i = 1'b0;
        funct3_i = 3'b0; addr_i = '0; store_data_i = '0; dmem_rdata = '0; dmem_resp = 1'b0;
        fmt_f3 = '0; fmt_off = '0; fmt_rdata = '0;
        @(posedge clk); #1;
        test_reset();
        test_store_word();
        test_store_narrow();
        test_loads();
        test_illegal();
        test_write_wins();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        test_formatter();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

endmodule
